// File: rtl/dec_sel_sequencer.sv
// dec_sel_sequencer: steps a 3-bit select code through 0..7 for a 3-to-8 decoder.
// Each code is held for dwell+1 cycles. The sequencer runs as a single pass or
// continuously, under start/stop/hold control. All outputs come straight from flops.
module dec_sel_sequencer #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               hold,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [0:2]         sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               wrap,
    output logic               done
);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StHold
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         sel_q, sel_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               wrap_q, wrap_d;
    logic               done_q, done_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               mode_q, mode_d;

    // Next-state logic. In SCAN and HOLD, stop wins over hold, and hold wins over advancing.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mode_d  = mode_q;

        case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d = StScan;
                    sel_d   = 3'd0;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    dwell_d = dwell;
                    mode_d  = mode;
                    cnt_d   = dwell;
                end
            end
            StScan: begin
                if (stop) begin
                    state_d = StIdle;
                    sel_d   = 3'd0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (hold) begin
                    // Freeze sel/cnt. No advance on the cycle hold is first seen.
                    state_d = StHold;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (sel_q != 3'd7) begin
                    sel_d = sel_q + 3'd1;
                    cnt_d = dwell_q;
                end else if (mode_q) begin
                    sel_d  = 3'd0;
                    cnt_d  = dwell_q;
                    wrap_d = 1'b1;
                end else begin
                    state_d = StIdle;
                    sel_d   = 3'd0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            StHold: begin
                if (stop) begin
                    state_d = StIdle;
                    sel_d   = 3'd0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (!hold) begin
                    // Resume from the frozen count on the following cycle.
                    state_d = StScan;
                end
            end
            default: begin
                state_d = StIdle;
                sel_d   = 3'd0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= 3'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
        end
    end

    // sel[0] is the MSB, so positional assignment keeps the numeric value.
    assign sel       = sel_q;
    assign sel_valid = valid_q;
    assign busy      = busy_q;
    assign wrap      = wrap_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dec_sel_sequencer.sv
// Testbench for dec_sel_sequencer. It runs directed scenarios and a random run.
// The reference model tracks scan progress as a linear count of advancing cycles.
module tb_dec_sel_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start, stop, hold, mode;
    logic [7:0] dwell;
    logic [0:2] sel;
    logic       sel_valid, busy, wrap, done;

    int checks   = 0;
    int failures = 0;

    // Reference model state. prog counts the advancing cycles since start.
    bit m_run, m_held, m_mode, m_wrap, m_done;
    int m_prog, m_d;

    dec_sel_sequencer #(.DWELL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .hold      (hold),
        .mode      (mode),
        .dwell     (dwell),
        .sel       (sel),
        .sel_valid (sel_valid),
        .busy      (busy),
        .wrap      (wrap),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] m_sel();
        return m_run ? 3'((m_prog / (m_d + 1)) % 8) : 3'd0;
    endfunction

    // Expected and actual outputs, packed as {sel, sel_valid, busy, wrap, done}.
    function automatic logic [6:0] exp_vec();
        return {m_sel(), m_run, m_run, m_wrap, m_done};
    endfunction

    function automatic logic [6:0] act_vec();
        return {sel, sel_valid, busy, wrap, done};
    endfunction

    task automatic model_reset();
        m_run = 0; m_held = 0; m_mode = 0; m_wrap = 0; m_done = 0;
        m_prog = 0; m_d = 0;
    endtask

    // Apply the current inputs to the model for one rising edge.
    task automatic model_step();
        m_wrap = 0;
        m_done = 0;
        if (!m_run) begin
            if (start && !stop) begin
                m_run = 1; m_held = 0; m_prog = 0; m_d = int'(dwell); m_mode = mode;
            end
        end else if (stop) begin
            m_run = 0;
        end else if (hold) begin
            m_held = 1;
        end else if (m_held) begin
            m_held = 0;
        end else begin
            m_prog++;
            if (m_prog == 8 * (m_d + 1)) begin
                if (m_mode) begin
                    m_prog = 0;
                    m_wrap = 1;
                end else begin
                    m_run  = 0;
                    m_done = 1;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; hold = 0;
    endtask

    task automatic test_reset();
        rst_n = 1; idle_inputs(); mode = 0; dwell = 0;
        model_reset();
        #1 rst_n = 0;
        #1;
        checks++;
        if (act_vec() !== 7'd0) begin
            failures++;
            $display("FAIL reset_init: actual=%b expected=%b", act_vec(), 7'd0);
        end
        @(posedge clk);
        #2 rst_n = 1;
        tick();
        checks++;
        if (act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_idle: actual=%b expected=%b", act_vec(), exp_vec());
        end
        // Bring the scan to sel=5, then assert reset between clock edges.
        start = 1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            start = 0;
        end
        checks++;
        if (sel !== 3'd5 || act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_presel: actual=%b expected=%b", act_vec(), exp_vec());
        end
        #2 rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (sel !== 3'd0 || sel_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0
            || wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: actual=%b expected=%b", act_vec(), 7'd0);
        end
        tick();
        #2 rst_n = 1;
        tick();
        checks++;
        if (act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_release: actual=%b expected=%b", act_vec(), exp_vec());
        end
    endtask

    task automatic test_single_pass();
        idle_inputs(); mode = 0; dwell = 0; start = 1;
        for (int t = 1; t <= 11; t++) begin
            tick();
            start = 0;
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL single_model t=%0d: actual=%b expected=%b",
                         t, act_vec(), exp_vec());
            end
            checks++;
            if (done !== (t == 9) || sel_valid !== (t <= 8)) begin
                failures++;
                $display("FAIL single_done t=%0d: done=%b valid=%b expected done=%b valid=%b",
                         t, done, sel_valid, (t == 9), (t <= 8));
            end
            if (t <= 8) begin
                checks++;
                if (sel !== 3'(t - 1)) begin
                    failures++;
                    $display("FAIL single_sel t=%0d: actual=%0d expected=%0d", t, sel, t - 1);
                end
            end
        end
    endtask

    task automatic test_dwell();
        idle_inputs(); mode = 0; dwell = 2; start = 1;
        for (int t = 1; t <= 27; t++) begin
            tick();
            start = 0;
            if (t == 2) dwell = 5;  // Must not affect the running scan.
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL dwell_model t=%0d: actual=%b expected=%b",
                         t, act_vec(), exp_vec());
            end
            checks++;
            if (done !== (t == 25) || (t <= 24 && sel !== 3'((t - 1) / 3))) begin
                failures++;
                $display("FAIL dwell_seq t=%0d: sel=%0d done=%b expected sel=%0d done=%b",
                         t, sel, done, (t - 1) / 3, (t == 25));
            end
        end
    endtask

    task automatic test_continuous();
        idle_inputs(); mode = 1; dwell = 1; start = 1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            start = 0;
            checks++;
            if (act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL cont_model t=%0d: actual=%b expected=%b",
                         t, act_vec(), exp_vec());
            end
            checks++;
            if (wrap !== (t == 17 || t == 33) || done !== 1'b0
                || sel !== 3'(((t - 1) / 2) % 8)) begin
                failures++;
                $display("FAIL cont_seq t=%0d: sel=%0d wrap=%b done=%b expected sel=%0d wrap=%b",
                         t, sel, wrap, done, ((t - 1) / 2) % 8, (t == 17 || t == 33));
            end
        end
        stop = 1;
        tick();
        stop = 0;
        checks++;
        if (act_vec() !== 7'd0 || act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL cont_stop: actual=%b expected=%b", act_vec(), 7'd0);
        end
    endtask

    task automatic test_hold();
        idle_inputs(); mode = 0; dwell = 3; start = 1;
        // After 11 edges the scan sits at sel=2 with one count left.
        for (int t = 1; t <= 11; t++) begin
            tick();
            start = 0;
        end
        hold = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (sel !== 3'd2 || sel_valid !== 1'b1 || act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL hold_frozen i=%0d: actual=%b expected=%b",
                         i, act_vec(), exp_vec());
            end
        end
        hold = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (sel !== ((i < 2) ? 3'd2 : 3'd3) || act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL hold_resume i=%0d: actual=%b expected=%b sel=%0d",
                         i, act_vec(), exp_vec(), (i < 2) ? 2 : 3);
            end
        end
        stop = 1;
        tick();
        stop = 0;
    endtask

    task automatic test_conflicts();
        // start together with stop in IDLE must not launch a scan.
        idle_inputs(); mode = 0; dwell = 0; start = 1; stop = 1;
        tick();
        idle_inputs();
        checks++;
        if (busy !== 1'b0 || act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL conf_startstop: actual=%b expected=%b", act_vec(), exp_vec());
        end
        // stop together with hold.
        dwell = 1; start = 1;
        for (int t = 1; t <= 3; t++) begin
            tick();
            start = 0;
        end
        hold = 1; stop = 1;
        tick();
        idle_inputs();
        checks++;
        if (act_vec() !== 7'd0 || act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL conf_stophold: actual=%b expected=%b", act_vec(), 7'd0);
        end
        // stop on the last code of a single pass: no done.
        dwell = 0; start = 1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            start = 0;
        end
        stop = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            stop = 0;
            checks++;
            if (act_vec() !== 7'd0 || act_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL conf_stoplast i=%0d: actual=%b expected=%b",
                         i, act_vec(), 7'd0);
            end
        end
        // start during a scan is ignored, as are the dwell/mode presented with it.
        dwell = 2; start = 1;
        for (int t = 1; t <= 4; t++) begin
            tick();
            start = 0;
        end
        start = 1; dwell = 0; mode = 1;
        tick();
        start = 0;
        checks++;
        if (sel !== 3'd1 || act_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL conf_restart: actual=%b expected=%b", act_vec(), exp_vec());
        end
        stop = 1;
        tick();
        stop = 0;
    endtask

    task automatic test_random();
        idle_inputs();
        for (int i = 0; i < 2000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 31) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            mode  = $urandom_range(0, 1) != 0;
            dwell = 8'($urandom_range(0, 3));
            tick();
            checks++;
            if (act_vec() !== exp_vec() || (wrap && done)) begin
                failures++;
                $display("FAIL random i=%0d: actual=%b expected=%b", i, act_vec(), exp_vec());
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_dwell();
        test_continuous();
        test_hold();
        test_conflicts();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
